tmds_encoder_array: RTL and testbench
=====================================

# tmds_encoder_array

Parametrised, two-stage pipelined TMDS encoder for `CHANNELS` lanes sharing one mode select. Each lane emits a 10-bit TMDS symbol per clock-enabled cycle: DC-balanced video data, control, guard band, or HDMI data-island TERC4. It sits between the video timing/packet generator and the serialisers, replacing per-lane single-mode encoders.

## Interface
Parameters:
- `CHANNELS`, 3: number of TMDS lanes (≥1).

Ports:
- `clk`  in  1  symbol clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ce`  in  1  clock enable; the pipeline and disparity counters advance only when high.
- `mode`  in  2  shared mode: 0 control, 1 video, 2 data island (TERC4), 3 guard band.
- `vd`  in  8*CHANNELS  video byte, lane i = `vd[8i+7:8i]`.
- `cd`  in  2*CHANNELS  control bits, lane i = `cd[2i+1:2i]`.
- `terc`  in  4*CHANNELS  TERC4 nibble, lane i = `terc[4i+3:4i]`.
- `tmds`  out  10*CHANNELS  encoded symbol, lane i = `tmds[10i+9:10i]`; bit 0 is transmitted first.

Clock and reset: one clock; reset is asynchronous and active-low.

## Operation
- Stage 1, per lane, on `ce`:
  - Compute N = popcount(vd).
  - Use XNOR when N>4, or N==4 and vd[0]==0.
  - q_m[0]=vd[0]; q_m[k]=q_m[k-1]^vd[k]^xnor for k=1..7; q_m[8]=~xnor.
  - Register q_m, popcount(q_m[7:0]), `mode`, `cd` and `terc`.
- Stage 2, video mode, per lane: signed 5-bit disparity counter `cnt`. Let N1 = ones in q_m[7:0] and N0 = 8−N1.
  - If cnt==0 or N1==N0: out={~q_m8, q_m8, q_m8 ? q_m[7:0] : ~q_m[7:0]}; cnt += q_m8 ? N1−N0 : N0−N1.
  - Else if (cnt>0 and N1>N0) or (cnt<0 and N0>N1): out={1, q_m8, ~q_m[7:0]}; cnt += 2·q_m8 + N0−N1.
  - Else: out={0, q_m8, q_m[7:0]}; cnt += −2·~q_m8 + N1−N0.
  - The update is evaluated on the pre-update cnt; arithmetic is 5-bit two's complement and cannot leave ±16.
- Stage 2, non-video modes: cnt←0 (all lanes).
- Control codes (cd[1:0]): 00→1101010100, 01→0010101011, 10→0101010100, 11→1010101011.
- Guard band: even-index lanes 1011001100, odd-index lanes 0100110011.
- TERC4 codes, 0..15: 1010011100, 1001100011, 1011100100, 1011100010, 0101110001, 0100011110, 0110001110, 0100111100, 1011001100, 0100111001, 0110011100, 1011000110, 1010001110, 1001110001, 0101100011, 1011000011.
- Symbol values above are written MSB (bit 9) first.
- Lanes are independent; no inter-lane state.

## Timing
- Latency: 2 `ce`-qualified cycles from input to `tmds`.
- Mode, cd and terc are pipelined alongside the data, so a mode change takes effect on exactly the symbol it accompanied.
- `ce` low: all registers, including cnt and `tmds`, hold.
- Reset (async assert, any time, including mid-stream):
  - `tmds`=0 and cnt=0 on every lane.
  - Stage-1 registers clear to mode=control, cd=0.
  - After release, the first `ce` cycle outputs 1101010100 on every lane.
- The first video symbol after any non-video symbol starts from cnt=0.
- Simultaneous `ce` and reset deassertion: reset dominates that edge.

## Configuration
- `TMDS_DATA_ISLAND_EN` defined: modes 2 and 3 behave as specified above.
- `TMDS_DATA_ISLAND_EN` undefined:
  - Modes 2 and 3 encode as control mode (cnt←0).
  - `terc` is ignored.
  - The TERC4 and guard-band logic is not synthesised.

## Test plan
- Reset: hold `rst_n`=0 → `tmds`=0 on all lanes. Release with ce=1, mode=0, cd=0 → next edge 1101010100, after 2 edges still 1101010100.
- Video disparity, lane 0: vd=0x00 for three cycles from cnt=0 → outputs 0x100, 0x3FF, 0x100; cnt goes −8, +2, −6.
- Mode interleave: video 0x00 ×2, then control cd=2'b11 (→1010101011), then video 0x00 → 0x100, confirming cnt cleared.
- `ce` stall: drop ce for 5 cycles mid video stream → `tmds` and cnt frozen; the sequence resumes identically to the unstalled reference model.
- Data island (macro on): mode=2, terc=4'hC → 1010001110 after 2 cycles. Mode=3 → lane0 1011001100, lane1 0100110011. Macro off: the same stimuli give control codes.
- Async reset mid-stream: assert `rst_n` between edges during video → `tmds`=0 immediately. After release, the first video 0x00 → 0x100.

Source files
------------

// File: rtl/tmds_encoder_array_if.sv
// tmds_encoder_array_if: shared mode, per-lane payload and encoded symbol bus for the TMDS encoder array.
// The master drives clock enable and payload; the encoder (slave) returns the 10-bit symbols.
interface tmds_encoder_array_if #(parameter int CHANNELS = 3);
  logic                    ce;
  logic [1:0]              mode;
  logic [8*CHANNELS-1:0]   vd;
  logic [2*CHANNELS-1:0]   cd;
  logic [4*CHANNELS-1:0]   terc;
  logic [10*CHANNELS-1:0]  tmds;
  modport master (output ce, mode, vd, cd, terc, input tmds);
  modport slave (input ce, mode, vd, cd, terc, output tmds);
endinterface

// File: rtl/tmds_encoder_array.sv
// tmds_encoder_array: two-stage pipelined TMDS encoder (video/control, plus TERC4 and guard band when TMDS_DATA_ISLAND_EN is defined).
// Stage 1 performs transition minimisation; stage 2 does DC balancing and mode selection per lane.
module tmds_encoder_array #(
  parameter int CHANNELS = 3
) (
  input logic                 clk,
  input logic                 rst_n,
  tmds_encoder_array_if.slave bus
);
  localparam logic [9:0] CTRL_LUT [4] = '{
    10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
  };
`ifdef TMDS_DATA_ISLAND_EN
  localparam logic [9:0] TERC_LUT [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };
`endif
  logic [1:0] mode_d, mode_q;
  always_comb mode_d = bus.mode;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mode_q <= 2'd0;
    else if (bus.ce) mode_q <= mode_d;
  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
`ifdef TMDS_DATA_ISLAND_EN
    localparam logic [9:0] GUARD = (i % 2 == 0) ? 10'b1011001100 : 10'b0100110011;
    logic [3:0] terc_d, terc_q;
`endif
    logic [7:0] v;
    logic [3:0] n_vd, n1_d, n1_q;
    logic use_xnor;
    logic [8:0] qm_d, qm_q;
    logic [1:0] cd_d, cd_q;
    logic q8, bal, inv;
    logic signed [4:0] diff, vcnt, cnt_d, cnt_q;
    logic [9:0] vid, sym_d, sym_q;
    assign v = bus.vd[8*i +: 8];
    always_comb begin
      n_vd = '0;
      for (int k = 0; k < 8; k++) n_vd = n_vd + 4'(v[k]);
      use_xnor = (n_vd > 4'd4) || (n_vd == 4'd4 && !v[0]);
      qm_d = '0;
      qm_d[0] = v[0];
      for (int k = 1; k < 8; k++) qm_d[k] = qm_d[k-1] ^ v[k] ^ use_xnor;
      qm_d[8] = ~use_xnor;
      n1_d = '0;
      for (int k = 0; k < 8; k++) n1_d = n1_d + 4'(qm_d[k]);
      cd_d = bus.cd[2*i +: 2];
`ifdef TMDS_DATA_ISLAND_EN
      terc_d = bus.terc[4*i +: 4];
`endif
    end
    // diff is N1-N0 = 2*N1-8, wrapped to the 5-bit counter width
    always_comb begin
      q8 = qm_q[8];
      diff = 5'({n1_q, 1'b0} - 5'd8);
      bal = (cnt_q == 5'sd0) || (n1_q == 4'd4);
      inv = (cnt_q > 5'sd0 && n1_q > 4'd4) || (cnt_q < 5'sd0 && n1_q < 4'd4);
      vid = bal ? {~q8, q8, q8 ? qm_q[7:0] : ~qm_q[7:0]}
          : inv ? {1'b1, q8, ~qm_q[7:0]}
          : {1'b0, q8, qm_q[7:0]};
      vcnt = bal ? cnt_q + (q8 ? diff : -diff)
           : inv ? cnt_q + $signed({3'b000, q8, 1'b0}) - diff
           : cnt_q + diff - $signed({3'b000, ~q8, 1'b0});
`ifdef TMDS_DATA_ISLAND_EN
      sym_d = mode_q == 2'd1 ? vid
            : mode_q == 2'd2 ? TERC_LUT[terc_q]
            : mode_q == 2'd3 ? GUARD
            : CTRL_LUT[cd_q];
`else
      sym_d = mode_q == 2'd1 ? vid : CTRL_LUT[cd_q];
`endif
      cnt_d = mode_q == 2'd1 ? vcnt : 5'sd0;
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        qm_q  <= '0;
        n1_q  <= '0;
        cd_q  <= '0;
        cnt_q <= '0;
        sym_q <= '0;
      end else if (bus.ce) begin
        qm_q  <= qm_d;
        n1_q  <= n1_d;
        cd_q  <= cd_d;
        cnt_q <= cnt_d;
        sym_q <= sym_d;
      end
`ifdef TMDS_DATA_ISLAND_EN
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) terc_q <= '0;
      else if (bus.ce) terc_q <= terc_d;
`endif
    assign bus.tmds[10*i +: 10] = sym_q;
  end
endmodule

// File: tb/tb_tmds_encoder_array.sv
// tb_tmds_encoder_array: scoreboard bench for tmds_encoder_array; a behavioural lane model predicts every symbol.
// Follows TMDS_DATA_ISLAND_EN the same way as the design.
module tb_tmds_encoder_array;
  localparam int CH = 3;
  localparam logic [9:0] CTRL_TAB [4] = '{
    10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
  };
  localparam logic [9:0] TERC_TAB [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };
  typedef struct {
    logic [10*CH-1:0] sym;
    int               c0;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  tmds_encoder_array_if #(.CHANNELS(CH)) bus ();
  tmds_encoder_array #(.CHANNELS(CH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  exp_t sb[$];
  exp_t last;
  exp_t rst_entry;
  int cnt_m[CH];
  int n_assert = 0;
  int n_fail = 0;
  function automatic logic [9:0] enc_video(input logic [7:0] d, input int lane);
    int n, n1, n0;
    bit x;
    logic [8:0] q;
    logic [9:0] r;
    n = $countones(d);
    x = (n > 4) || (n == 4 && d[0] == 1'b0);
    q[0] = d[0];
    for (int k = 1; k < 8; k++) q[k] = x ? ~(q[k-1] ^ d[k]) : (q[k-1] ^ d[k]);
    q[8] = !x;
    n1 = $countones(q[7:0]);
    n0 = 8 - n1;
    if (cnt_m[lane] == 0 || n1 == n0) begin
      r = q[8] ? {2'b01, q[7:0]} : {2'b10, ~q[7:0]};
      cnt_m[lane] += q[8] ? n1 - n0 : n0 - n1;
    end else if ((cnt_m[lane] > 0 && n1 > n0) || (cnt_m[lane] < 0 && n0 > n1)) begin
      r = {1'b1, q[8], ~q[7:0]};
      cnt_m[lane] += (q[8] ? 2 : 0) + n0 - n1;
    end else begin
      r = {1'b0, q[8], q[7:0]};
      cnt_m[lane] += (q[8] ? 0 : -2) + n1 - n0;
    end
    return r;
  endfunction
  function automatic exp_t model(input logic [1:0] m, input logic [8*CH-1:0] v,
                                 input logic [2*CH-1:0] cv, input logic [4*CH-1:0] t);
    exp_t e;
    logic [9:0] s;
    e.sym = '0;
    for (int i = 0; i < CH; i++) begin
      if (m == 2'd1) s = enc_video(v[8*i +: 8], i);
      else begin
        cnt_m[i] = 0;
`ifdef TMDS_DATA_ISLAND_EN
        s = m == 2'd2 ? TERC_TAB[t[4*i +: 4]]
          : m == 2'd3 ? ((i % 2 == 0) ? 10'b1011001100 : 10'b0100110011)
          : CTRL_TAB[cv[2*i +: 2]];
`else
        s = CTRL_TAB[cv[2*i +: 2]];
`endif
      end
      e.sym[10*i +: 10] = s;
    end
    e.c0 = cnt_m[0];
    return e;
  endfunction
  task automatic check(input string tag, input exp_t e);
    int got_cnt;
    got_cnt = int'(dut.g_lane[0].cnt_q);
    n_assert++;
    assert (bus.tmds === e.sym) else begin
      n_fail++;
      $error("FAIL %s_sym got=%h exp=%h", tag, bus.tmds, e.sym);
    end
    n_assert++;
    assert (got_cnt === e.c0) else begin
      n_fail++;
      $error("FAIL %s_cnt0 got=%0d exp=%0d", tag, got_cnt, e.c0);
    end
  endtask
  task automatic step(input string tag, input logic c, input logic [1:0] m, input logic [8*CH-1:0] v,
                      input logic [2*CH-1:0] cv, input logic [4*CH-1:0] t);
    bus.ce = c;
    bus.mode = m;
    bus.vd = v;
    bus.cd = cv;
    bus.terc = t;
    if (c) sb.push_back(model(m, v, cv, t));
    @(posedge clk);
    #1;
    if (c) last = sb.pop_front();
    check(tag, last);
  endtask
  task automatic rst_model();
    sb.delete();
    for (int i = 0; i < CH; i++) cnt_m[i] = 0;
    last.sym = '0;
    last.c0 = 0;
  endtask
  initial begin
    rst_entry.sym = {CH{10'b1101010100}};
    rst_entry.c0 = 0;
    rst_model();
    bus.ce = 1'b1;
    bus.mode = 2'd0;
    bus.vd = '0;
    bus.cd = '0;
    bus.terc = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", last);
    rst_n = 1'b1;
    sb.push_back(rst_entry);
    step("rel0", 1'b1, 2'd0, '0, '0, '0);
    step("rel1", 1'b1, 2'd0, '0, '0, '0);
    for (int k = 0; k < 3; k++) step("vid00", 1'b1, 2'd1, '0, '0, '0);
    step("flush_a", 1'b1, 2'd1, '0, '0, '0);
    step("ctrl_a", 1'b1, 2'd0, '0, '0, '0);
    step("il_v0", 1'b1, 2'd1, '0, '0, '0);
    step("il_v1", 1'b1, 2'd1, '0, '0, '0);
    step("il_c", 1'b1, 2'd0, '0, {CH{2'b11}}, '0);
    step("il_v2", 1'b1, 2'd1, '0, '0, '0);
    step("il_v3", 1'b1, 2'd1, {CH{8'hA5}}, '0, '0);
    for (int k = 0; k < 16; k++) begin
      if (k >= 6 && k < 11) step("stall", 1'b0, 2'($urandom_range(3)), 24'($urandom), 6'($urandom), 12'($urandom));
      else step("vstream", 1'b1, 2'd1, 24'($urandom), '0, '0);
    end
    step("di_terc", 1'b1, 2'd2, '0, '0, {CH{4'hC}});
    step("di_guard", 1'b1, 2'd3, '0, '0, {CH{4'hC}});
    step("di_flush", 1'b1, 2'd1, {CH{8'hFF}}, '0, '0);
    for (int k = 0; k < 40; k++)
      step("mix", 1'($urandom_range(4) != 0), 2'($urandom_range(3)), 24'($urandom), 6'($urandom), 12'($urandom));
    for (int k = 0; k < 4; k++) step("pre_rst", 1'b1, 2'd1, 24'($urandom), '0, '0);
    #3;
    rst_n = 1'b0;
    rst_model();
    #1;
    check("async_rst", last);
    @(posedge clk);
    #1;
    check("rst_low", last);
    rst_n = 1'b1;
    sb.push_back(rst_entry);
    step("post0", 1'b1, 2'd1, '0, '0, '0);
    step("post1", 1'b1, 2'd1, '0, '0, '0);
    step("post2", 1'b1, 2'd0, '0, '0, '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
